jtcop_pal_dma: RTL and testbench
================================

# jtcop_pal_dma

Palette DMA writer for the DECO-style colour mixer: copies a full palette image, one 16-bit word per entry, from a CPU-side source RAM into the video palette RAM. Its output port is the one the colour mixer's CPU write port would otherwise drive. A CPU strobe arms a transfer, and the copy runs during the next vertical blank so the mixer never reads a half-written entry mid-frame. It sits between the CPU/work-RAM fabric and the palette dual-port RAM write side.

## Interface
- AW, 10, palette word-address width (entries = 2^AW)
- SRC_OFS, 0, word offset added to source address (AW bits, wraps)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- LVBL  in  1  vertical blank, active low (low = blanking)
- dma_trig  in  1  single-cycle arm strobe from CPU register decode
- src_cs  out  1  source read request
- src_addr  out  AW  source word address
- src_data  in  16  source read data
- src_ok  in  1  source data valid for current src_addr
- pal_addr  out  AW  palette RAM word address
- pal_dout  out  16  palette write data
- pal_we  out  2  byte write enables {hi,lo}
- busy  out  1  high from arm until transfer completes or aborts
- done  out  1  one-cycle pulse on successful completion
- abort  out  1  sticky: last transfer cut short by end of vblank

## Operation
- Reset: state IDLE. Outputs: src_cs=0, src_addr=SRC_OFS, pal_addr=0, pal_dout=0, pal_we=0, busy=0, done=0, abort=0. The pending flag and the previous-LVBL register are cleared.
- dma_trig sets pending. It also clears abort, except when the trigger lands in the same cycle an abort is raised; then abort stays set and pending is still set.
- busy = pending | (state != IDLE).
- vb_start = previous LVBL high & current LVBL low, computed from a registered copy of LVBL.
- States:
  - IDLE: on vb_start & pending, clear pending, set index=0, go READ. Otherwise stay.
  - READ: src_cs=1, src_addr=SRC_OFS+index (mod 2^AW).
    - The first cycle of each READ is a settle cycle; src_ok is ignored in it.
    - From the second cycle on, src_ok=1 latches src_data into pal_dout and moves to WRITE.
  - WRITE: src_cs=0, pal_addr=index, pal_we=2'b11 for exactly one cycle.
    - If index = 2^AW-1: go DONE.
    - Otherwise index+1, go READ.
  - DONE: done=1 for one cycle, go IDLE.
- Abort: in READ or WRITE, LVBL high (vblank ended) forces IDLE at the next edge.
  - abort is set and pal_we is forced to 0 in that cycle; no write occurs after vblank ends.
  - pending is not re-set by the abort itself.
- Trigger while a transfer is running: pending is set and the next vblank performs a fresh full copy.
- Trigger in the same cycle as DONE: pending is set.
- Index arithmetic is AW bits unsigned. The source address wraps modulo 2^AW.

## Timing
- dma_trig at cycle t: pending and busy are high from t+1.
- vb_start detected at cycle v (LVBL sampled low): src_cs=1 from v+1.
- Per word, minimum 3 cycles: READ settle, READ with src_ok, WRITE. Each extra src_ok wait cycle adds one.
- Full copy with AW=10 and zero-wait source: 3072 cycles from the first src_cs to the last pal_we, then done one cycle later.
- pal_dout and pal_addr are valid in the same cycle as pal_we. The palette RAM captures them on that cycle's edge.
- Reset mid-transfer: IDLE on the next edge. No pal_we is asserted in the reset cycle.

## Structure
- Package jtcop_pal_pkg holds the state enum (IDLE, READ, WRITE, DONE) and the default AW constant.
- A single module is sufficient; the LVBL edge detect is inline.
- The optional sub-module jtcop_pal_dma_fsm holds only the state register and next-state logic when formal checking is wanted.

## Test plan
- Reset then no trigger; toggle LVBL for 2 frames -> src_cs and pal_we never assert, busy=0.
- Trigger at cycle 10; vblank starts at cycle 100; source returns word = 0xA000|addr with src_ok one cycle after settle -> 1024 writes, pal_addr 0..1023, data 0xA000..0xA3FF, done pulses exactly once, busy drops the cycle after done.
- SRC_OFS=0x3F0 -> pal_addr 0 receives source 0x3F0; pal_addr 0x10 receives source 0x000 (wrap).
- Source holds src_ok low for 5 cycles on every word -> each word takes 3+4 cycles; no duplicate or missing writes.
- LVBL rises after 100 writes -> abort=1, state IDLE, no further pal_we. The next trigger clears abort and the following vblank completes all 1024 writes.
- Trigger during a running copy and in the DONE cycle -> pending set; a second full copy starts at the next vb_start.

Source files
------------

// File: rtl/jtcop_pal_pkg.sv
// Shared types and defaults for the palette DMA writer.
package jtcop_pal_pkg;

    localparam int unsigned DefaultAw = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } pal_dma_state_e;

endpackage

// File: rtl/jtcop_pal_dma.sv
// Palette DMA writer: copies a full palette image from a CPU-side source RAM
// into the palette RAM during the vertical blank that follows a CPU arm strobe.
module jtcop_pal_dma
    import jtcop_pal_pkg::*;
#(
    parameter int unsigned   AW      = DefaultAw,
    parameter logic [AW-1:0] SRC_OFS = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          dma_trig,
    output logic          src_cs,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_data,
    input  logic          src_ok,
    output logic [AW-1:0] pal_addr,
    output logic [15:0]   pal_dout,
    output logic [1:0]    pal_we,
    output logic          busy,
    output logic          done,
    output logic          abort
);

    pal_dma_state_e state_q;
    logic [AW-1:0]  index_q;
    logic [AW-1:0]  index_inc;
    logic           settle_q;
    logic           pending_q;
    logic           lvbl_q;
    logic           src_cs_q;
    logic [AW-1:0]  src_addr_q;
    logic [AW-1:0]  pal_addr_q;
    logic [15:0]    pal_dout_q;
    logic [1:0]     pal_we_q;
    logic           done_q;
    logic           abort_q;

    logic vb_start;
    logic active;
    logic cut;
    logic start;

    assign index_inc = index_q + {{(AW-1){1'b0}}, 1'b1};
    assign vb_start  = lvbl_q & ~LVBL;
    assign active    = (state_q == StRead) || (state_q == StWrite);
    assign cut       = active & LVBL;
    assign start     = (state_q == StIdle) & vb_start & pending_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            index_q    <= '0;
            settle_q   <= 1'b0;
            pending_q  <= 1'b0;
            lvbl_q     <= 1'b0;
            src_cs_q   <= 1'b0;
            src_addr_q <= SRC_OFS;
            pal_addr_q <= '0;
            pal_dout_q <= '0;
            pal_we_q   <= 2'b00;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            lvbl_q   <= LVBL;
            done_q   <= 1'b0;
            pal_we_q <= 2'b00;

            // A new arm always wins over the start that consumes the old one.
            if (dma_trig) begin
                pending_q <= 1'b1;
            end else if (start) begin
                pending_q <= 1'b0;
            end

            if (cut) begin
                abort_q <= 1'b1;
            end else if (dma_trig) begin
                abort_q <= 1'b0;
            end

            if (cut) begin
                state_q  <= StIdle;
                src_cs_q <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            index_q    <= '0;
                            settle_q   <= 1'b1;
                            src_cs_q   <= 1'b1;
                            src_addr_q <= SRC_OFS;
                            state_q    <= StRead;
                        end
                    end
                    StRead: begin
                        settle_q <= 1'b0;
                        if (!settle_q && src_ok) begin
                            pal_dout_q <= src_data;
                            pal_addr_q <= index_q;
                            pal_we_q   <= 2'b11;
                            src_cs_q   <= 1'b0;
                            state_q    <= StWrite;
                        end
                    end
                    StWrite: begin
                        if (&index_q) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            index_q    <= index_inc;
                            src_addr_q <= SRC_OFS + index_inc;
                            src_cs_q   <= 1'b1;
                            settle_q   <= 1'b1;
                            state_q    <= StRead;
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign src_cs   = src_cs_q;
    assign src_addr = src_addr_q;
    assign pal_addr = pal_addr_q;
    assign pal_dout = pal_dout_q;
    // The strobe is registered; gate it so nothing lands once vblank ends or during reset.
    assign pal_we   = (rst_n && !LVBL) ? pal_we_q : 2'b00;
    assign busy     = pending_q | (state_q != StIdle);
    assign done     = done_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_jtcop_pal_dma.sv
// Directed bench for jtcop_pal_dma: a scenario table plus hand-written corner sequences.
module tb_jtcop_pal_dma;

    logic        clk;
    logic        rst_n;
    logic        LVBL;
    logic        dma_trig;
    logic        src_ok;

    logic        src_cs, src_cs2;
    logic [9:0]  src_addr, src_addr2;
    logic [15:0] src_data, src_data2;
    logic [9:0]  pal_addr, pal_addr2;
    logic [15:0] pal_dout, pal_dout2;
    logic [1:0]  pal_we, pal_we2;
    logic        busy, busy2, done, done2, abort, abort2;

    jtcop_pal_dma #(.AW(10), .SRC_OFS(10'h000)) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dma_trig(dma_trig),
        .src_cs(src_cs), .src_addr(src_addr), .src_data(src_data), .src_ok(src_ok),
        .pal_addr(pal_addr), .pal_dout(pal_dout), .pal_we(pal_we),
        .busy(busy), .done(done), .abort(abort)
    );

    jtcop_pal_dma #(.AW(10), .SRC_OFS(10'h3F0)) dut_ofs (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .dma_trig(dma_trig),
        .src_cs(src_cs2), .src_addr(src_addr2), .src_data(src_data2), .src_ok(src_ok),
        .pal_addr(pal_addr2), .pal_dout(pal_dout2), .pal_we(pal_we2),
        .busy(busy2), .done(done2), .abort(abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM model: word = 0xA000 | address, ready ok_delay cycles into a request.
    int ok_delay = 1;
    int ok_cnt   = 0;
    int cyc      = 0;
    assign src_data  = 16'hA000 | {6'd0, src_addr};
    assign src_data2 = 16'hA000 | {6'd0, src_addr2};
    assign src_ok    = src_cs && (ok_cnt >= ok_delay);
    always @(posedge clk) ok_cnt <= src_cs ? ok_cnt + 1 : 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    int wcount, data_err, done_cnt, first_cs, last_we, done_cyc, vb_cyc, w2, err2;
    logic [15:0] mem2 [1024];

    always @(negedge clk) begin
        logic [9:0] a2;
        if (src_cs && first_cs < 0) first_cs = cyc;
        if (pal_we != 2'b00) begin
            if (pal_we != 2'b11 || pal_addr != 10'(wcount) ||
                pal_dout != (16'hA000 | {6'd0, pal_addr})) data_err++;
            wcount++;
            last_we = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pal_we2 != 2'b00) begin
            a2 = pal_addr2 + 10'h3F0;
            if (pal_addr2 != 10'(w2) || pal_dout2 != (16'hA000 | {6'd0, a2})) err2++;
            mem2[pal_addr2] = pal_dout2;
            w2++;
        end
        if ({src_cs2, busy2, done2, abort2} != {src_cs, busy, done, abort}) err2++;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        wcount = 0; data_err = 0; done_cnt = 0; first_cs = -1;
        last_we = 0; done_cyc = 0; w2 = 0; err2 = 0;
        foreach (mem2[i]) mem2[i] = 16'h0000;
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1 dma_trig = 1'b1;
        @(posedge clk); #1 dma_trig = 1'b0;
    endtask

    task automatic vblank_start();
        @(posedge clk); #1 LVBL = 1'b0;
        vb_cyc = cyc;
    endtask

    task automatic vblank_end();
        @(posedge clk); #1 LVBL = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < budget);
        check(nm, done, 1);
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wcount < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
    endtask

    typedef struct {
        int ok_delay;
        int cut;        // abort after this many writes, 0 = run to completion
        int phase;      // extra cycles after that write before vblank ends
        int exp_writes;
        int exp_span;   // first src_cs to last pal_we, 0 = not checked
        int exp_done;
        int exp_abort;
        int chk_ofs;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d_", idx);
        clear_mon();
        ok_delay = v.ok_delay;
        pulse_trig();
        check({p, "armed_busy"}, busy, 1);
        check({p, "armed_abort"}, abort, 0);
        repeat (20) @(posedge clk);
        vblank_start();
        if (v.cut > 0) begin
            wait_writes(v.cut);
            repeat (v.phase) @(posedge clk);
            #1 LVBL = 1'b1;
            repeat (10) @(posedge clk);
            #1;
        end else begin
            wait_done(20000, {p, "done_seen"});
            @(posedge clk); #1;
            check({p, "busy_after_done"}, busy, 0);
            vblank_end();
            repeat (10) @(posedge clk);
            #1;
        end
        check({p, "writes"}, wcount, v.exp_writes);
        check({p, "data_err"}, data_err, 0);
        check({p, "done_count"}, done_cnt, v.exp_done);
        check({p, "abort"}, abort, v.exp_abort);
        check({p, "busy_end"}, busy, 0);
        check({p, "cs_latency"}, first_cs - vb_cyc, 1);
        if (v.exp_span > 0) check({p, "span"}, last_we - first_cs + 1, v.exp_span);
        if (v.exp_done > 0) check({p, "done_gap"}, done_cyc - last_we, 1);
        if (v.chk_ofs != 0) begin
            check({p, "ofs_pal0"}, mem2[0], 16'hA3F0);
            check({p, "ofs_pal10"}, mem2[16], 16'hA000);
            check({p, "ofs_err"}, err2, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1, 0,   0, 1024, 3072, 1, 0, 1};
        vecs[1] = '{0, 0,   0, 1024, 3072, 1, 0, 0};
        vecs[2] = '{5, 0,   0, 1024, 7168, 1, 0, 0};
        vecs[3] = '{1, 100, 0, 100,  0,    0, 1, 0};
        vecs[4] = '{1, 50,  2, 50,   0,    0, 1, 0};
        vecs[5] = '{1, 0,   0, 1024, 3072, 1, 0, 0};

        rst_n = 1'b0; LVBL = 1'b1; dma_trig = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {src_cs, src_addr, pal_addr, pal_dout, pal_we, busy, done, abort}, 0);
        check("reset_src_addr_ofs", src_addr2, 10'h3F0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Two frames without an arm: nothing may happen.
        repeat (2) begin
            repeat (30) @(posedge clk);
            vblank_start();
            repeat (30) @(posedge clk);
            vblank_end();
        end
        repeat (5) @(posedge clk); #1;
        check("idle_no_cs", first_cs, -1);
        check("idle_no_we", wcount, 0);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Re-arm during a copy, then in the DONE cycle: each buys one more full copy.
        clear_mon();
        ok_delay = 1;
        pulse_trig();
        repeat (5) @(posedge clk);
        vblank_start();
        wait_writes(10);
        #1 dma_trig = 1'b1;
        @(posedge clk); #1 dma_trig = 1'b0;
        wait_done(5000, "run1_done");
        repeat (20) @(posedge clk); #1;
        check("run1_no_restart", wcount, 1024);
        check("run1_pending", busy, 1);
        vblank_end();
        repeat (5) @(posedge clk);
        vblank_start();
        wait_done(5000, "run2_done");
        dma_trig = 1'b1;
        @(posedge clk); #1 dma_trig = 1'b0;
        check("run2_pending", busy, 1);
        check("run2_writes", wcount, 2048);
        vblank_end();
        repeat (5) @(posedge clk);
        vblank_start();
        wait_done(5000, "run3_done");
        @(posedge clk); #1;
        check("run3_idle", busy, 0);
        check("run3_writes", wcount, 3072);
        check("run3_data_err", data_err, 0);
        vblank_end();

        // Arm in the very cycle vblank ends mid-copy: abort stays, pending is kept.
        repeat (5) @(posedge clk);
        clear_mon();
        pulse_trig();
        repeat (5) @(posedge clk);
        vblank_start();
        wait_writes(3);
        #1 LVBL = 1'b1; dma_trig = 1'b1;
        @(posedge clk); #1 dma_trig = 1'b0;
        check("trig_abort_abort", abort, 1);
        check("trig_abort_pending", busy, 1);
        repeat (5) @(posedge clk); #1;
        check("trig_abort_writes", wcount, 3);

        // Reset asserted during a WRITE cycle.
        clear_mon();
        vblank_start();
        wait_writes(5);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_we_gated", pal_we, 0);
        @(posedge clk); #1;
        check("rst_idle", {busy, src_cs, done, abort}, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("rst_writes", wcount, 5);
        check("rst_stays_idle", busy, 0);
        LVBL = 1'b1;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
